// File: rtl/robo_sequenciador_atuadores.sv
// Timed actuator sequencer: runs one-hot motion commands for fixed durations,
// inserts a dead-time guard after each, and latches an emergency stop on the cliff sensor.
module robo_sequenciador_atuadores #(
    parameter int T_AVANCO  = 8,
    parameter int T_GIRO    = 12,
    parameter int T_REMOCAO = 20,
    parameter int T_GUARDA  = 2,
    parameter int CNT_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_avancar,
    input  logic        cmd_girar,
    input  logic        cmd_remover,
    input  logic        under,
    output logic        motor_esq,
    output logic        motor_dir,
    output logic        braco,
    output logic        done,
    output logic        erro,
    output logic [15:0] passos,
    output logic [2:0]  estado
);

    // Handshake: a command transfers on a rising edge where cmd_valid and the
    // registered cmd_ready are both 1 (and under is 0); cmd_* is ignored otherwise.
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        AVANCANDO = 3'd1,
        GIRANDO   = 3'd2,
        REMOVENDO = 3'd3,
        GUARDA    = 3'd4,
        PARADO    = 3'd5
    } estado_t;

    localparam logic [CNT_W-1:0] CARGA_AVANCO  = CNT_W'(T_AVANCO - 1);
    localparam logic [CNT_W-1:0] CARGA_GIRO    = CNT_W'(T_GIRO - 1);
    localparam logic [CNT_W-1:0] CARGA_REMOCAO = CNT_W'(T_REMOCAO - 1);
    localparam logic [CNT_W-1:0] CARGA_GUARDA  = CNT_W'(T_GUARDA - 1);

    estado_t          state;
    logic [CNT_W-1:0] contador;
    logic [2:0]       cmd_sel;

    assign cmd_sel = {cmd_avancar, cmd_girar, cmd_remover};
    assign estado  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= OCIOSO;
            contador  <= '0;
            passos    <= '0;
            motor_esq <= 1'b0;
            motor_dir <= 1'b0;
            braco     <= 1'b0;
            done      <= 1'b0;
            erro      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            erro <= 1'b0;
            // The cliff sensor overrides everything, including a completing command.
            if (under && state != PARADO) begin
                state     <= PARADO;
                motor_esq <= 1'b0;
                motor_dir <= 1'b0;
                braco     <= 1'b0;
                cmd_ready <= 1'b0;
            end else begin
                case (state)
                    OCIOSO: begin
                        if (cmd_valid) begin
                            case (cmd_sel)
                                3'b100: begin
                                    state     <= AVANCANDO;
                                    contador  <= CARGA_AVANCO;
                                    motor_esq <= 1'b1;
                                    motor_dir <= 1'b1;
                                    cmd_ready <= 1'b0;
                                end
                                3'b010: begin
                                    state     <= GIRANDO;
                                    contador  <= CARGA_GIRO;
                                    motor_esq <= 1'b1;
                                    cmd_ready <= 1'b0;
                                end
                                3'b001: begin
                                    state     <= REMOVENDO;
                                    contador  <= CARGA_REMOCAO;
                                    braco     <= 1'b1;
                                    cmd_ready <= 1'b0;
                                end
                                default: erro <= 1'b1;
                            endcase
                        end
                    end
                    AVANCANDO, GIRANDO, REMOVENDO: begin
                        if (contador == '0) begin
                            state     <= GUARDA;
                            contador  <= CARGA_GUARDA;
                            motor_esq <= 1'b0;
                            motor_dir <= 1'b0;
                            braco     <= 1'b0;
                            done      <= 1'b1;
                            if (state == AVANCANDO && passos != 16'hFFFF)
                                passos <= passos + 16'd1;
                        end else begin
                            contador <= contador - 1'b1;
                        end
                    end
                    GUARDA: begin
                        if (contador == '0) begin
                            state     <= OCIOSO;
                            cmd_ready <= 1'b1;
                        end else begin
                            contador <= contador - 1'b1;
                        end
                    end
                    PARADO: begin
                        state <= PARADO;
                    end
                    default: begin
                        state     <= PARADO;
                        motor_esq <= 1'b0;
                        motor_dir <= 1'b0;
                        braco     <= 1'b0;
                        cmd_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
